// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive-side byte FIFO.
// Byte width and default FIFO geometry live here.
package uart_rx_fifo_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int DATA_W_DEF  = UART_BYTE_W;
    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_ADDR_W = $clog2(FIFO_DEPTH);

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side write and consumer-side read signals for uart_rx_fifo.
// The master drives receiver and consumer inputs; the FIFO is the slave.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = FIFO_ADDR_W
);

    logic [DATA_W-1:0] rx_data;
    logic              rx_flag;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              ovf_clr;

    modport master (
        output rx_data, rx_flag, rd_en, ovf_clr,
        input  rd_data, rd_valid, empty, full, count, overflow
    );

    modport slave (
        input  rx_data, rx_flag, rd_en, ovf_clr,
        output rd_data, rd_valid, empty, full, count, overflow
    );

endinterface

// File: rtl/uart_rx_fifo_edge_fall_detect.sv
// Falling-edge detector on the receiver busy flag.
// Register starts low so reset release never yields a pulse.
module edge_fall_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic fall_o
);

    logic flag_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= sig_i;
        end
    end

    assign fall_o = flag_q & ~sig_i;

endmodule

// File: rtl/uart_rx_fifo.sv
// Circular byte FIFO behind a UART receiver with fill level,
// registered read port and sticky overflow.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input logic           baud_clk,
    input logic           reset,
    uart_rx_fifo_if.slave bus
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              ovf_q, ovf_d;

    logic push, pop, push_ok, drop;

    edge_fall_detect u_fall (
        .clk_i  (baud_clk),
        .rst_i  (reset),
        .sig_i  (bus.rx_flag),
        .fall_o (push)
    );

    // A full FIFO still accepts a byte when a pop frees a slot this cycle.
    assign pop     = bus.rd_en & ~empty_q;
    assign push_ok = push & (~full_q | pop);
    assign drop    = push & full_q & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop;
        ovf_d      = ovf_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
            rd_data_d = mem_q[rd_ptr_q];
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end

        empty_d = (count_d == '0);
        full_d  = (count_d == FULL_CNT);
    end

    always_ff @(posedge baud_clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.rx_data;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.count    = count_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo.
// Each task drives one scenario and checks hand-computed values inline.
module tb_uart_rx_fifo;

    logic baud_clk = 1'b0;
    logic reset    = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
        .baud_clk (baud_clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 baud_clk = ~baud_clk;

    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask

    // Two cycles: busy high, then busy low with the byte presented.
    task automatic send_frame(input logic [7:0] b);
        bus.rx_flag = 1'b1;
        tick();
        bus.rx_flag = 1'b0;
        bus.rx_data = b;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++;
        if (bus.empty !== 1'b1) begin
            n_err++;
            $display("FAIL reset_empty: got %b want 1", bus.empty);
        end
        n_cmp++;
        if (bus.count !== 5'd0 || bus.full !== 1'b0) begin
            n_err++;
            $display("FAIL reset_count: got %0d/%b want 0/0", bus.count, bus.full);
        end
        n_cmp++;
        if (bus.rd_data !== 8'h00 || bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out: got %h/%b want 00/0", bus.rd_data, bus.overflow);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (bus.rd_valid !== 1'b0 || bus.count !== 5'd0) begin
                n_err++;
                $display("FAIL idle_%0d: got v=%b c=%0d want v=0 c=0", i, bus.rd_valid, bus.count);
            end
        end
    endtask

    task automatic test_single();
        send_frame(8'hA5);
        n_cmp++;
        if (bus.count !== 5'd1 || bus.empty !== 1'b0) begin
            n_err++;
            $display("FAIL single_push: got c=%0d e=%b want c=1 e=0", bus.count, bus.empty);
        end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        n_cmp++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hA5) begin
            n_err++;
            $display("FAIL single_pop: got v=%b d=%h want v=1 d=a5", bus.rd_valid, bus.rd_data);
        end
        n_cmp++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin
            n_err++;
            $display("FAIL single_cnt: got c=%0d e=%b want c=0 e=1", bus.count, bus.empty);
        end
        tick();
        n_cmp++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'hA5) begin
            n_err++;
            $display("FAIL single_after: got v=%b d=%h want v=0 d=a5", bus.rd_valid, bus.rd_data);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) send_frame(8'(i));
        n_cmp++;
        if (bus.count !== 5'd16 || bus.full !== 1'b1) begin
            n_err++;
            $display("FAIL fill_full: got c=%0d f=%b want c=16 f=1", bus.count, bus.full);
        end
        bus.rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp = 8'(i);
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
                n_err++;
                $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, bus.rd_valid, bus.rd_data, exp);
            end
        end
        n_cmp++;
        if (bus.empty !== 1'b1 || bus.count !== 5'd0) begin
            n_err++;
            $display("FAIL drain_empty: got e=%b c=%0d want e=1 c=0", bus.empty, bus.count);
        end
        tick();
        bus.rd_en = 1'b0;
        n_cmp++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h0F) begin
            n_err++;
            $display("FAIL rd_empty: got v=%b d=%h want v=0 d=0f", bus.rd_valid, bus.rd_data);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i));
        send_frame(8'hFF);
        n_cmp++;
        if (bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
            n_err++;
            $display("FAIL ovf_set: got o=%b c=%0d want o=1 c=16", bus.overflow, bus.count);
        end
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        n_cmp++;
        if (bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_clr: got %b want 0", bus.overflow);
        end
        bus.rx_flag = 1'b1;
        tick();
        bus.rx_flag = 1'b0;
        bus.rx_data = 8'hEE;
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        n_cmp++;
        if (bus.overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_set_wins: got %b want 1", bus.overflow);
        end
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            exp = 8'h20 + 8'(i);
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
                n_err++;
                $display("FAIL ovf_drain_%0d: got v=%b d=%h want v=1 d=%h", i, bus.rd_valid, bus.rd_data, exp);
            end
        end
        bus.rd_en = 1'b0;
        tick();
        n_cmp++;
        if (bus.empty !== 1'b1 || bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_end: got e=%b o=%b want e=1 o=0", bus.empty, bus.overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) send_frame(8'h30 + 8'(i));
        bus.rx_flag = 1'b1;
        tick();
        bus.rx_flag = 1'b0;
        bus.rx_data = 8'h55;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        n_cmp++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h30) begin
            n_err++;
            $display("FAIL fpp_pop: got v=%b d=%h want v=1 d=30", bus.rd_valid, bus.rd_data);
        end
        n_cmp++;
        if (bus.count !== 5'd16 || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
            n_err++;
            $display("FAIL fpp_cnt: got c=%0d f=%b o=%b want 16/1/0", bus.count, bus.full, bus.overflow);
        end
        bus.rd_en = 1'b1;
        for (int i = 1; i < 17; i++) begin
            tick();
            exp = (i == 16) ? 8'h55 : 8'h30 + 8'(i);
            n_cmp++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp) begin
                n_err++;
                $display("FAIL fpp_drain_%0d: got v=%b d=%h want v=1 d=%h", i, bus.rd_valid, bus.rd_data, exp);
            end
        end
        bus.rd_en = 1'b0;
        n_cmp++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin
            n_err++;
            $display("FAIL fpp_end: got c=%0d e=%b want 0/1", bus.count, bus.empty);
        end
    endtask

    task automatic test_push_pop_empty();
        tick();
        bus.rx_flag = 1'b1;
        tick();
        bus.rx_flag = 1'b0;
        bus.rx_data = 8'h77;
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        n_cmp++;
        if (bus.rd_valid !== 1'b0 || bus.count !== 5'd1 || bus.empty !== 1'b0) begin
            n_err++;
            $display("FAIL ppe: got v=%b c=%0d e=%b want 0/1/0", bus.rd_valid, bus.count, bus.empty);
        end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        n_cmp++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h77) begin
            n_err++;
            $display("FAIL ppe_pop: got v=%b d=%h want v=1 d=77", bus.rd_valid, bus.rd_data);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) send_frame(8'h90 + 8'(i));
        n_cmp++;
        if (bus.count !== 5'd5) begin
            n_err++;
            $display("FAIL mid_fill: got %0d want 5", bus.count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.rd_data !== 8'h00) begin
            n_err++;
            $display("FAIL mid_reset: got c=%0d e=%b d=%h want 0/1/00", bus.count, bus.empty, bus.rd_data);
        end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        n_cmp++;
        if (bus.rd_valid !== 1'b0 || bus.count !== 5'd0) begin
            n_err++;
            $display("FAIL mid_rd: got v=%b c=%0d want 0/0", bus.rd_valid, bus.count);
        end
    endtask

    initial begin
        bus.rx_data = '0;
        bus.rx_flag = 1'b0;
        bus.rd_en   = 1'b0;
        bus.ovf_clr = 1'b0;
        test_reset();
        test_single();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_push_pop_empty();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
